dmem_arbiter: RTL

- Two-port arbiter and sequencer in front of the single-port data memory (DMem).
- Port 0 is the core load/store unit; port 1 is the debug/DMA loader that preloads and inspects memory.
- Grants one requester at a time, drives the DMem strobes for exactly one cycle, captures DMem's registered read data and returns it with a done pulse.
- Blocks port-1 writes into the special ROM/IO window unless the parameter enables them.

---
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port arbiter/sequencer in front of the single-port DMem.
//            Port 0 = core LSU, port 1 = debug/DMA loader. One access is
//            in flight at a time: gnt -> DMem strobe -> done, 3 cycles each.
//            Port-1 writes into the ROM/IO window (addr[PROT_BIT]) are
//            dropped and flagged unless P1_IO_WR_EN is set.
// Ports    : clk, rst (async, active-low)
//            p0_*/p1_* : req/we/addr/wdata in, gnt/done/rdata out
//            p1_err    : pulses with p1_done when a protected write is dropped
//            mem_*     : DMem strobes/address/data; mem_rdata registered
//            busy      : high while an access is in flight
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
   parameter int FIXED_PRIO  = 0,
   parameter int PROT_BIT    = 20,
   parameter int P1_IO_WR_EN = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p0_req,
   input  logic [3:0]  p0_we,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   output logic        p0_gnt,
   output logic        p0_done,
   output logic [31:0] p0_rdata,
   input  logic        p1_req,
   input  logic [3:0]  p1_we,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p1_gnt,
   output logic        p1_done,
   output logic [31:0] p1_rdata,
   output logic        p1_err,
   output logic        mem_rd,
   output logic [3:0]  mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   state_t      r_state;
   logic        r_ptr;        // 1 = port 1 wins the next contested grant
   logic        r_port;       // port owning the access in flight
   logic        r_prot;       // access is a dropped protected write
   logic [3:0]  r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_p0_rsel;    // done cycle of a port-0 read: pass mem_rdata
   logic        r_p1_rsel;
   logic [31:0] r_p0_hold;
   logic [31:0] r_p1_hold;
   logic        w_sel1;
   logic        w_any;

   always_comb begin
      w_sel1 = p1_req;
      if (p0_req && p1_req)
         w_sel1 = (FIXED_PRIO != 0) ? 1'b0 : r_ptr;
   end

   assign w_any = p0_req | p1_req;
   assign busy  = (r_state != S_IDLE);

   // DMem data_out is registered, so read data only exists in the done
   // cycle itself; it is forwarded combinationally there and captured into
   // the hold register on the following edge (DMem output is stable then
   // because no strobe is issued during the done cycle).
   assign p0_rdata = r_p0_rsel ? mem_rdata : r_p0_hold;
   assign p1_rdata = r_p1_rsel ? mem_rdata : r_p1_hold;

   // All outputs are registered: the actions of a state become visible in
   // the cycle after it, giving gnt at T, strobe at T+1 and done at T+2.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_ptr     <= 1'b0;
         r_port    <= 1'b0;
         r_prot    <= 1'b0;
         r_we      <= 4'b0000;
         r_addr    <= 32'd0;
         r_wdata   <= 32'd0;
         r_p0_rsel <= 1'b0;
         r_p1_rsel <= 1'b0;
         r_p0_hold <= 32'd0;
         r_p1_hold <= 32'd0;
         p0_gnt    <= 1'b0;
         p1_gnt    <= 1'b0;
         p0_done   <= 1'b0;
         p1_done   <= 1'b0;
         p1_err    <= 1'b0;
         mem_rd    <= 1'b0;
         mem_we    <= 4'b0000;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
      end else begin
         p0_gnt    <= 1'b0;
         p1_gnt    <= 1'b0;
         p0_done   <= 1'b0;
         p1_done   <= 1'b0;
         p1_err    <= 1'b0;
         mem_rd    <= 1'b0;
         mem_we    <= 4'b0000;
         r_p0_rsel <= 1'b0;
         r_p1_rsel <= 1'b0;
         if (r_p0_rsel)
            r_p0_hold <= mem_rdata;
         if (r_p1_rsel)
            r_p1_hold <= mem_rdata;

         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  p0_gnt  <= ~w_sel1;
                  p1_gnt  <= w_sel1;
                  r_port  <= w_sel1;
                  r_we    <= w_sel1 ? p1_we    : p0_we;
                  r_addr  <= w_sel1 ? p1_addr  : p0_addr;
                  r_wdata <= w_sel1 ? p1_wdata : p0_wdata;
                  r_prot  <= w_sel1 && (P1_IO_WR_EN == 0) &&
                             (p1_we != 4'b0000) && p1_addr[PROT_BIT];
                  // Pointer only rotates when both ports actually competed.
                  if (p0_req && p1_req && (FIXED_PRIO == 0))
                     r_ptr <= ~r_ptr;
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               mem_addr  <= r_addr;
               mem_wdata <= r_wdata;
               mem_rd    <= (r_we == 4'b0000);
               mem_we    <= r_prot ? 4'b0000 : r_we;
               r_state   <= S_RESP;
            end
            S_RESP: begin
               if (r_port) begin
                  p1_done   <= 1'b1;
                  p1_err    <= r_prot;
                  r_p1_rsel <= (r_we == 4'b0000);
               end else begin
                  p0_done   <= 1'b1;
                  r_p0_rsel <= (r_we == 4'b0000);
               end
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
